// File: rtl/burst_line_pkg.sv
// burst_line_pkg: shared types and constants for the burst RAM line port.
//   state_t           : line port FSM states
//   DEF_*             : default geometry used as parameter defaults
//   LINE_BITWIDTH     : bits in one line at the default geometry
//   BEAT_IDX_W        : beat counter width at the default geometry
//   CMD_READ/CMD_WRITE: RAM cmd encodings
package burst_line_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WRITE_BEATS,
    READ_WAIT,
    READ_BEATS,
    DONE
  } state_t;

  // Beat counter width; kept at least 1 so a counter always exists.
  function automatic int beat_idx_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

  localparam int   DEF_DATA_BITWIDTH = 64;
  localparam int   DEF_BURST_COUNT   = 4;
  localparam int   LINE_BITWIDTH     = DEF_DATA_BITWIDTH * DEF_BURST_COUNT;
  localparam int   BEAT_IDX_W        = beat_idx_width(DEF_BURST_COUNT);

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_line_port.sv
// burst_line_port: client-side front end for the burst RAM.
// Takes one whole-line read or write, runs the RAM cmd/cmd_en/busy handshake,
// serializes write lines into beats and gathers read beats into a line.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_*               client request (valid/ready, direction, line, data, mask)
//   resp_valid          one-cycle completion pulse
//   resp_rd_line        gathered read line
//   resp_error          read watchdog expired (qualified by resp_valid)
//   cmd/cmd_en/addr     RAM command interface
//   wr_data/data_mask   RAM write beat and byte mask (1 = byte not written)
//   rd_data/rd_data_valid RAM read beats
//   busy                RAM cannot accept a command
//
// Build option: define BURST_LINE_PORT_TIMEOUT_EN to enable the read
// watchdog (TIMEOUT_CYCLES without a beat ends the read with resp_error=1).
// Without it resp_error is tied to 0 and reads wait forever.
module burst_line_port
  import burst_line_pkg::*;
#(
  parameter int ADDR_BITWIDTH  = 4,
  parameter int BURST_COUNT    = DEF_BURST_COUNT,
  parameter int DATA_BITWIDTH  = DEF_DATA_BITWIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic                                        req_write,
  input  logic [ADDR_BITWIDTH-$clog2(BURST_COUNT)-1:0] req_line_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]        req_wr_line,
  input  logic [DATA_BITWIDTH/8*BURST_COUNT-1:0]      req_wr_mask,
  output logic                                        resp_valid,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0]        resp_rd_line,
  output logic                                        resp_error,
  output logic                                        cmd,
  output logic                                        cmd_en,
  output logic [ADDR_BITWIDTH-1:0]                    addr,
  output logic [DATA_BITWIDTH-1:0]                    wr_data,
  output logic [DATA_BITWIDTH/8-1:0]                  data_mask,
  input  logic [DATA_BITWIDTH-1:0]                    rd_data,
  input  logic                                        rd_data_valid,
  input  logic                                        busy
);

  localparam int BEAT_W  = beat_idx_width(BURST_COUNT);
  localparam int LINE_W  = DATA_BITWIDTH * BURST_COUNT;
  localparam int MASK_W  = DATA_BITWIDTH / 8;
  localparam int LMASK_W = MASK_W * BURST_COUNT;
  localparam int LADDR_W = ADDR_BITWIDTH - $clog2(BURST_COUNT);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, next_beat;
  logic [LADDR_W-1:0]  line_addr_q;
  logic                write_q;
  logic [LINE_W-1:0]   wr_line_q;
  logic [LMASK_W-1:0]  wr_mask_q;

  logic                 cmd_en_d, cmd_d, resp_valid_d, resp_error_d;
  logic [ADDR_BITWIDTH-1:0] addr_d;
  logic [DATA_BITWIDTH-1:0] wr_data_d;
  logic [MASK_W-1:0]    data_mask_d;
  logic [LINE_W-1:0]    line_d;
  logic                 accept;

  // Gate with rst so ready reads 0 while reset is held.
  assign req_ready = rst && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign next_beat = beat_q + 1'b1;

`ifdef BURST_LINE_PORT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cmd_en_d     = 1'b0;
    cmd_d        = cmd;
    addr_d       = addr;
    wr_data_d    = '0;
    data_mask_d  = '0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    line_d       = resp_rd_line;
`ifdef BURST_LINE_PORT_TIMEOUT_EN
    tmo_d        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          // Clear so beats missing after a watchdog expiry read as 0.
          if (!req_write) line_d = '0;
        end
      end
      ISSUE: begin
        if (!busy) begin
          cmd_en_d = 1'b1;
          cmd_d    = write_q ? CMD_WRITE : CMD_READ;
          addr_d   = {line_addr_q, {BEAT_W{1'b0}}};
          beat_d   = '0;
          if (write_q) begin
            // Beat 0 goes out alongside the command strobe.
            wr_data_d   = wr_line_q[0 +: DATA_BITWIDTH];
            data_mask_d = wr_mask_q[0 +: MASK_W];
            state_d     = WRITE_BEATS;
          end else begin
            state_d = READ_WAIT;
          end
        end
      end
      WRITE_BEATS: begin
        // beat_q names the beat currently on the bus.
        if (beat_q == LAST_BEAT) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end else begin
          beat_d      = next_beat;
          wr_data_d   = wr_line_q[int'(next_beat)*DATA_BITWIDTH +: DATA_BITWIDTH];
          data_mask_d = wr_mask_q[int'(next_beat)*MASK_W +: MASK_W];
        end
      end
      READ_WAIT, READ_BEATS: begin
        if (rd_data_valid) begin
          line_d[int'(beat_q)*DATA_BITWIDTH +: DATA_BITWIDTH] = rd_data;
          if (beat_q == LAST_BEAT) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end else begin
            beat_d  = next_beat;
            state_d = READ_BEATS;
          end
        end
`ifdef BURST_LINE_PORT_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      cmd_en       <= 1'b0;
      cmd          <= CMD_READ;
      addr         <= '0;
      wr_data      <= '0;
      data_mask    <= '0;
      resp_valid   <= 1'b0;
      resp_rd_line <= '0;
      line_addr_q  <= '0;
      write_q      <= 1'b0;
      wr_line_q    <= '0;
      wr_mask_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      cmd_en       <= cmd_en_d;
      cmd          <= cmd_d;
      addr         <= addr_d;
      wr_data      <= wr_data_d;
      data_mask    <= data_mask_d;
      resp_valid   <= resp_valid_d;
      resp_rd_line <= line_d;
      if (accept) begin
        line_addr_q <= req_line_addr;
        write_q     <= req_write;
        if (req_write) begin
          wr_line_q <= req_wr_line;
          wr_mask_q <= req_wr_mask;
        end
      end
    end
  end

`ifdef BURST_LINE_PORT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q      <= '0;
      resp_error <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      resp_error <= resp_error_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^{resp_error_d, TIMEOUT_CYCLES};
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_burst_line_port.sv
// tb_burst_line_port: directed bench for burst_line_port with a behavioural
// burst RAM (4-cycle read latency, 16 words, byte masks) preloaded below.
module tb_burst_line_port;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [1:0]    req_line_addr;
  logic [255:0]  req_wr_line;
  logic [31:0]   req_wr_mask;
  logic          resp_valid, resp_error;
  logic [255:0]  resp_rd_line;
  logic          cmd, cmd_en;
  logic [3:0]    addr;
  logic [63:0]   wr_data;
  logic [7:0]    data_mask;
  logic [63:0]   rd_data = '0;
  logic          rd_data_valid = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  burst_line_port dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_line_addr(req_line_addr), .req_wr_line(req_wr_line), .req_wr_mask(req_wr_mask),
    .resp_valid(resp_valid), .resp_rd_line(resp_rd_line), .resp_error(resp_error),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy)
  );

  // ---------------- burst RAM model ----------------
  logic [63:0] mem [16] = '{
    64'h3F5A2E14B7C6A980, 64'h9D8E2F17AB4C3E6F, 64'hA1C3F7E2D5B8A9C4, 64'h7D4E9F2C1B6A3D8F,
    64'h6C4B9A8D2F5E3C7A, 64'hE1A7D0B5C8F3E6A9, 64'hF8E9D2C3B4A5F6E7, 64'hD4E7F2C5B8A3D6E9,
    64'h0808080808080808, 64'h0909090909090909, 64'h0A0A0A0A0A0A0A0A, 64'h0B0B0B0B0B0B0B0B,
    64'h0C0C0C0C0C0C0C0C, 64'h0D0D0D0D0D0D0D0D, 64'h0E0E0E0E0E0E0E0E, 64'h0F0F0F0F0F0F0F0F
  };
  logic [3:0] wr_ptr = '0, rd_ptr = '0;
  int         wr_left = 0, rd_left = 0, rd_delay = 0;
  logic       gap_mode, no_valid, gap_ph = 1'b0;

  always @(posedge clk) begin
    rd_data_valid <= 1'b0;
    rd_data       <= '0;
    if (rd_left > 0) begin
      if (rd_delay > 0) rd_delay <= rd_delay - 1;
      else if (gap_mode && gap_ph) gap_ph <= 1'b0;
      else begin
        rd_data_valid <= 1'b1;
        rd_data       <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 4'd1;
        rd_left       <= rd_left - 1;
        gap_ph        <= 1'b1;
      end
    end
    if (cmd_en === 1'b1) begin
      if (cmd) begin
        for (int b = 0; b < 8; b++)
          if (!data_mask[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
        wr_ptr  <= addr + 4'd1;
        wr_left <= 3;
      end else if (!no_valid) begin
        rd_ptr   <= addr;
        rd_left  <= 4;
        rd_delay <= 4;
        gap_ph   <= 1'b0;
      end
    end else if (wr_left > 0) begin
      for (int b = 0; b < 8; b++)
        if (!data_mask[b]) mem[wr_ptr][8*b +: 8] <= wr_data[8*b +: 8];
      wr_ptr  <= wr_ptr + 4'd1;
      wr_left <= wr_left - 1;
    end
  end

  // ---------------- monitor ----------------
  int   cyc = 0, acc_cyc = 0, resp_cyc = 0, last_rdv_cyc = 0;
  int   cmd_en_cnt = 0, resp_cnt = 0;
  logic last_cmd = 1'b0;
  logic [3:0] last_addr = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cyc <= cyc;
    if (cmd_en === 1'b1) begin
      cmd_en_cnt <= cmd_en_cnt + 1;
      last_cmd   <= cmd;
      last_addr  <= addr;
    end
    if (resp_valid === 1'b1) begin
      resp_cnt <= resp_cnt + 1;
      resp_cyc <= cyc;
    end
    if (rd_data_valid) last_rdv_cyc <= cyc;
  end

  // ---------------- checking helpers ----------------
  int errors = 0, checks = 0;
  logic [255:0] r_line;
  logic         r_err, r_found;
  int           n0, n1;

  localparam logic [255:0] LINE0 = {64'h7D4E9F2C1B6A3D8F, 64'hA1C3F7E2D5B8A9C4,
                                    64'h9D8E2F17AB4C3E6F, 64'h3F5A2E14B7C6A980};
  localparam logic [255:0] LINE1 = {64'hD4E7F2C5B8A3D6E9, 64'hF8E9D2C3B4A5F6E7,
                                    64'hE1A7D0B5C8F3E6A9, 64'h6C4B9A8D2F5E3C7A};
  localparam logic [255:0] WLINE = {64'h4444444444444444, 64'h3333333333333333,
                                    64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] WLINE_M = {64'h4444444444444444, 64'h3333333333333333,
                                      64'h2222222222222222, 64'hFFFFFFFF11111111};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic w, input logic [1:0] la,
                          input logic [255:0] wl, input logic [31:0] wm);
    req_valid = 1'b1; req_write = w; req_line_addr = la;
    req_wr_line = wl; req_wr_mask = wm;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_wr_line = '0; req_wr_mask = '0;
  endtask

  task automatic wait_resp(input int limit);
    r_found = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (resp_valid === 1'b1) begin
        r_found = 1'b1; r_line = resp_rd_line; r_err = resp_error;
        break;
      end
      @(negedge clk);
    end
    check("resp_seen", r_found, 1);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 0);
    check("ready_after_done", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_line_addr = '0;
    req_wr_line = '0; req_wr_mask = '0; busy = 1'b0; gap_mode = 1'b0; no_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_cmd_en", cmd_en, 0);
    check("rst_cmd", cmd, 0);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_data_mask", data_mask, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_resp_line", resp_rd_line, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // read line 0
    n0 = cmd_en_cnt;
    send_req(1'b0, 2'd0, '0, '0);
    check("rd0_ready_low", req_ready, 0);
    wait_resp(60);
    check("rd0_line", r_line, LINE0);
    check("rd0_error", r_err, 0);
    check("rd0_cmd_en_cnt", cmd_en_cnt - n0, 1);
    check("rd0_cmd", last_cmd, 0);
    check("rd0_addr", last_addr, 0);
    check("rd0_lat_after_beat", resp_cyc - last_rdv_cyc, 1);

    // read line 1 with gaps between beats
    gap_mode = 1'b1;
    send_req(1'b0, 2'd1, '0, '0);
    wait_resp(60);
    gap_mode = 1'b0;
    check("rd1_line", r_line, LINE1);
    check("rd1_addr", last_addr, 4);
    check("rd1_lat_after_beat", resp_cyc - last_rdv_cyc, 1);

    // write line 2, full mask enabled
    n0 = cmd_en_cnt;
    send_req(1'b1, 2'd2, WLINE, 32'h0);
    wait_resp(60);
    check("wr2_latency", resp_cyc - acc_cyc, 6);
    check("wr2_cmd", last_cmd, 1);
    check("wr2_addr", last_addr, 8);
    check("wr2_cmd_en_cnt", cmd_en_cnt - n0, 1);
    check("wr2_idle_wr_data", wr_data, 0);
    check("wr2_idle_mask", data_mask, 0);
    repeat (2) @(negedge clk);
    send_req(1'b0, 2'd2, '0, '0);
    wait_resp(60);
    check("rd2_line", r_line, WLINE);

    // masked write: beat 0 upper bytes only, other beats fully masked
    send_req(1'b1, 2'd2, {192'h0, 64'hFFFFFFFFFFFFFFFF}, 32'hFFFFFF0F);
    wait_resp(60);
    repeat (2) @(negedge clk);
    send_req(1'b0, 2'd2, '0, '0);
    wait_resp(60);
    check("rd2_masked_line", r_line, WLINE_M);

    // busy held for 5 cycles after accept
    busy = 1'b1;
    n0 = cmd_en_cnt;
    send_req(1'b0, 2'd0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      check("busy_cmd_en_low", cmd_en, 0);
      check("busy_ready_low", req_ready, 0);
      @(negedge clk);
    end
    check("busy_no_cmd", cmd_en_cnt - n0, 0);
    busy = 1'b0;
    wait_resp(60);
    check("busy_cmd_en_cnt", cmd_en_cnt - n0, 1);
    check("busy_line", r_line, LINE0);

    // reset in the middle of a read
    send_req(1'b0, 2'd1, '0, '0);
    r_found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (rd_data_valid) begin r_found = 1'b1; break; end
      @(negedge clk);
    end
    check("midrst_beat_seen", r_found, 1);
    rst = 1'b0;
    n1 = resp_cnt;
    @(negedge clk);
    check("midrst_ready_low", req_ready, 0);
    rst = 1'b1;
    n0 = cmd_en_cnt;
    repeat (12) @(negedge clk);
    check("midrst_no_resp", resp_cnt - n1, 0);
    check("midrst_no_cmd", cmd_en_cnt - n0, 0);
    check("midrst_ready", req_ready, 1);
    send_req(1'b0, 2'd0, '0, '0);
    wait_resp(60);
    check("midrst_next_line", r_line, LINE0);
    check("midrst_next_err", r_err, 0);

`ifdef BURST_LINE_PORT_TIMEOUT_EN
    // RAM never answers: watchdog must end the read with an error
    no_valid = 1'b1;
    send_req(1'b0, 2'd0, '0, '0);
    wait_resp(150);
    no_valid = 1'b0;
    check("tmo_error", r_err, 1);
    check("tmo_line_zero", r_line, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
